// File: rtl/tiny_alu_core.sv
// tiny_alu_core: small sequenced ALU with add/and/xor done in one cycle and a
// two-cycle multiply. Optional completed-operation counter is built only
// when TINYALU_OPCOUNT_EN is defined.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  IDLE     | accepts a command on every edge start is high
//  MUL_WAIT | multiply in flight on latched operands, busy high, start ignored
module tiny_alu_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result,
    output logic        busy,
    output logic        proto_err
`ifdef TINYALU_OPCOUNT_EN
    ,
    output logic [15:0] ops_done
`endif
);

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_RST = 3'b111;

    state_t      state_q, state_d;
    logic        cnt_q, cnt_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] result_q, result_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [8:0]  sum;
    logic [15:0] prod;

    // Only the multiply needs operands beyond the accept edge, so only it latches them.
    assign sum  = {1'b0, A} + {1'b0, B};
    assign prod = {8'b0, a_q} * {8'b0, b_q};

    // State register and datapath registers; reset wins over any command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 1'b0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            result_q <= 16'h0000;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state, command decode and multiply wait down-counter.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_ADD: begin
                            result_d = {7'b0, sum};
                            done_d   = 1'b1;
                        end
                        OP_AND: begin
                            result_d = {8'b0, A & B};
                            done_d   = 1'b1;
                        end
                        OP_XOR: begin
                            result_d = {8'b0, A ^ B};
                            done_d   = 1'b1;
                        end
                        OP_MUL: begin
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = 1'b1;
                            state_d = MUL_WAIT;
                        end
                        OP_RST: begin
                            result_d = 16'h0000;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            MUL_WAIT: begin
                if (start) begin
                    err_d = 1'b1;
                end
                if (cnt_q == 1'b0) begin
                    result_d = prod;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign done      = done_q;
    assign result    = result_q;
    assign busy      = (state_q == MUL_WAIT);
    assign proto_err = err_q;

`ifdef TINYALU_OPCOUNT_EN
    logic [15:0] ops_q;

    // Completion counter advances on the same edge that raises done; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            ops_q <= 16'h0000;
        end else if (done_d) begin
            ops_q <= ops_q + 16'h0001;
        end
    end

    assign ops_done = ops_q;
`endif

endmodule

// File: tb/tb_tiny_alu_core.sv
// Bench for tiny_alu_core: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a command-level model.
module tb_tiny_alu_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  A = 8'h00;
    logic [7:0]  B = 8'h00;
    logic [2:0]  op = 3'b000;
    logic        start = 1'b0;
    logic        done;
    logic [15:0] result;
    logic        busy;
    logic        proto_err;
`ifdef TINYALU_OPCOUNT_EN
    logic [15:0] ops_done;
`endif

    tiny_alu_core dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .op        (op),
        .start     (start),
        .done      (done),
        .result    (result),
        .busy      (busy),
        .proto_err (proto_err)
`ifdef TINYALU_OPCOUNT_EN
        ,
        .ops_done  (ops_done)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_no = 0;
    bit chk_en = 1'b0;

    // Model: a multiply is just "answer due at a given edge number".
    int          mul_due = -1;
    logic [15:0] mul_val = 16'h0;
    logic [15:0] m_result = 16'h0;
    logic        m_done = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_err = 1'b0;
    logic [15:0] m_ops = 16'h0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_no);
        end
    endtask

    always @(posedge clk) begin
        edge_no++;
        m_done = 1'b0;
        if (reset) begin
            mul_due  = -1;
            m_result = 16'h0;
            m_err    = 1'b0;
            m_ops    = 16'h0;
        end else if (mul_due >= 0) begin
            if (start) m_err = 1'b1;
            if (edge_no == mul_due) begin
                m_result = mul_val;
                m_done   = 1'b1;
                mul_due  = -1;
            end
        end else if (start) begin
            case (op)
                3'd1: begin m_result = 16'(int'(A) + int'(B)); m_done = 1'b1; end
                3'd2: begin m_result = {8'h00, A & B}; m_done = 1'b1; end
                3'd3: begin m_result = {8'h00, A ^ B}; m_done = 1'b1; end
                3'd4: begin mul_val = 16'(int'(A) * int'(B)); mul_due = edge_no + 2; end
                3'd7: m_result = 16'h0;
                default: ;
            endcase
        end
        if (m_done) m_ops = m_ops + 16'h1;
        m_busy = (mul_due >= 0);
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("done", {15'b0, done}, {15'b0, m_done});
            chk("result", result, m_result);
            chk("busy", {15'b0, busy}, {15'b0, m_busy});
            chk("proto_err", {15'b0, proto_err}, {15'b0, m_err});
`ifdef TINYALU_OPCOUNT_EN
            chk("ops_done", ops_done, m_ops);
`endif
        end
    end

    task automatic step(input logic r, input logic s, input logic [2:0] o,
                        input logic [7:0] a, input logic [7:0] b);
        reset = r; start = s; op = o; A = a; B = b;
        @(negedge clk);
    endtask

    int dones;

    initial begin
        @(negedge clk);
        step(1, 1, 3'd1, 8'h12, 8'h34);
        chk_en = 1'b1;
        chk("rst_result", result, 16'h0);
        chk("rst_done", {15'b0, done}, 16'h0);
        chk("rst_busy", {15'b0, busy}, 16'h0);
        chk("rst_err", {15'b0, proto_err}, 16'h0);

        // add with carry, single cycle, never busy
        step(0, 1, 3'd1, 8'hFF, 8'h01);
        chk("add_done", {15'b0, done}, 16'h1);
        chk("add_result", result, 16'h0100);
        chk("add_busy", {15'b0, busy}, 16'h0);
        step(0, 0, 3'd0, 8'h00, 8'h00);
        chk("add_done_drop", {15'b0, done}, 16'h0);
        chk("add_hold", result, 16'h0100);

        // multiply with operands changed during wait
        step(0, 1, 3'd4, 8'hFF, 8'hFF);
        chk("mul_busy1", {15'b0, busy}, 16'h1);
        chk("mul_nodone1", {15'b0, done}, 16'h0);
        step(0, 0, 3'd1, 8'h00, 8'h00);
        chk("mul_busy2", {15'b0, busy}, 16'h1);
        step(0, 0, 3'd1, 8'h00, 8'h00);
        chk("mul_done", {15'b0, done}, 16'h1);
        chk("mul_result", result, 16'hFE01);
        chk("mul_idle", {15'b0, busy}, 16'h0);

        // back-to-back and/xor
        step(0, 1, 3'd2, 8'hF0, 8'h3C);
        chk("and_result", result, 16'h0030);
        step(0, 1, 3'd3, 8'hF0, 8'h3C);
        chk("xor_done", {15'b0, done}, 16'h1);
        chk("xor_result", result, 16'h00CC);

        // no_op and reserved opcodes leave result alone; rst_op clears it
        step(0, 1, 3'd0, 8'h11, 8'h22);
        chk("noop_done", {15'b0, done}, 16'h0);
        chk("noop_result", result, 16'h00CC);
        step(0, 1, 3'd5, 8'h11, 8'h22);
        chk("op5_result", result, 16'h00CC);
        step(0, 1, 3'd7, 8'h11, 8'h22);
        chk("rstop_result", result, 16'h0000);
        chk("rstop_done", {15'b0, done}, 16'h0);

        // start during multiply: ignored, sticky error, one completion
        dones = 0;
        step(0, 1, 3'd4, 8'd3, 8'd4);
        dones += int'(done);
        step(0, 1, 3'd1, 8'd9, 8'd9);
        dones += int'(done);
        chk("perr_set", {15'b0, proto_err}, 16'h1);
        step(0, 0, 3'd0, 8'd0, 8'd0);
        dones += int'(done);
        chk("perr_result", result, 16'h000C);
        step(0, 0, 3'd0, 8'd0, 8'd0);
        dones += int'(done);
        step(0, 0, 3'd0, 8'd0, 8'd0);
        dones += int'(done);
        chk("perr_one_done", 16'(dones), 16'h1);
        chk("perr_sticky", {15'b0, proto_err}, 16'h1);

        // reset aborts multiply
        step(0, 1, 3'd4, 8'd2, 8'd2);
        step(1, 0, 3'd0, 8'd0, 8'd0);
        chk("abort_busy", {15'b0, busy}, 16'h0);
        chk("abort_result", result, 16'h0);
        chk("abort_err", {15'b0, proto_err}, 16'h0);
        step(0, 0, 3'd0, 8'd0, 8'd0);
        chk("abort_nodone", {15'b0, done}, 16'h0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 65),
                 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
        step(1, 0, 3'd0, 8'd0, 8'd0);

`ifdef TINYALU_OPCOUNT_EN
        for (int i = 0; i < 65535; i++) step(0, 1, 3'd1, 8'd1, 8'd1);
        chk("ops_preload", ops_done, 16'hFFFF);
        step(0, 1, 3'd1, 8'd1, 8'd2);
        chk("ops_wrap", ops_done, 16'h0000);
        step(0, 1, 3'd0, 8'd1, 8'd2);
        step(0, 1, 3'd7, 8'd1, 8'd2);
        chk("ops_noop_hold", ops_done, 16'h0000);
`endif

        step(0, 0, 3'd0, 8'd0, 8'd0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
